// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: 4x4 card-matching game controller.
// Cursor, flip/show/compare FSM, matched-pair tracking.
module memory_game_ctrl #(
  parameter int unsigned SHOW_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26,
  parameter logic [47:0] LAYOUT      = {
    3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd7,
    3'd6, 3'd5, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0
  }
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic        restart,
  output logic [3:0]  cursor,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic [3:0]  pairs_found,
  output logic        match_p,
  output logic        miss_p,
  output logic        busy,
  output logic        game_done
);

  typedef enum logic [2:0] {
    S_FIRST,
    S_SECOND,
    S_SHOW,
    S_CHECK,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cursor_q, cursor_d;
  logic [15:0]        face_q, face_d;
  logic [15:0]        match_q, match_d;
  logic [3:0]         pairs_q, pairs_d;
  logic               match_p_q, match_p_d;
  logic               miss_p_q, miss_p_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         first_q, first_d;
  logic [3:0]         second_q, second_d;

  logic               move;
  logic               sel_ok;
  logic [1:0]         row, col;
  logic [2:0]         val_a, val_b;

  assign move   = btn_up | btn_down | btn_left | btn_right;
  assign sel_ok = btn_sel & ~move & ~face_q[cursor_q];
  assign row    = cursor_q[3:2];
  assign col    = cursor_q[1:0];
  assign val_a  = LAYOUT[first_q*3 +: 3];
  assign val_b  = LAYOUT[second_q*3 +: 3];

  // Next-state logic: cursor, game FSM, restart override
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    face_d    = face_q;
    match_d   = match_q;
    pairs_d   = pairs_q;
    match_p_d = 1'b0;
    miss_p_d  = 1'b0;
    cnt_d     = cnt_q;
    first_d   = first_q;
    second_d  = second_q;

    if (state_q != S_DONE) begin
      priority case (1'b1)
        btn_up:    cursor_d = {row - 2'd1, col};
        btn_down:  cursor_d = {row + 2'd1, col};
        btn_left:  cursor_d = {row, col - 2'd1};
        btn_right: cursor_d = {row, col + 2'd1};
        default:   cursor_d = cursor_q;
      endcase
    end

    unique case (state_q)
      S_FIRST: begin
        if (sel_ok) begin
          face_d[cursor_q] = 1'b1;
          first_d          = cursor_q;
          state_d          = S_SECOND;
        end
      end
      S_SECOND: begin
        if (sel_ok) begin
          face_d[cursor_q] = 1'b1;
          second_d         = cursor_q;
          cnt_d            = CNT_W'(SHOW_CYCLES - 1);
          state_d          = S_SHOW;
        end
      end
      S_SHOW: begin
        if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CHECK: begin
        if (val_a == val_b) begin
          match_d[first_q]  = 1'b1;
          match_d[second_q] = 1'b1;
          pairs_d           = pairs_q + 4'd1;
          match_p_d         = 1'b1;
          if (pairs_q == 4'd7) begin
            face_d  = '1;
            match_d = '1;
            state_d = S_DONE;
          end else begin
            state_d = S_FIRST;
          end
        end else begin
          face_d[first_q]  = 1'b0;
          face_d[second_q] = 1'b0;
          miss_p_d         = 1'b1;
          state_d          = S_FIRST;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_FIRST;
    endcase

    if (restart) begin
      state_d   = S_FIRST;
      cursor_d  = '0;
      face_d    = '0;
      match_d   = '0;
      pairs_d   = '0;
      match_p_d = 1'b0;
      miss_p_d  = 1'b0;
      cnt_d     = '0;
      first_d   = '0;
      second_d  = '0;
    end

    busy_d = (state_d == S_SHOW) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FIRST;
      cursor_q  <= '0;
      face_q    <= '0;
      match_q   <= '0;
      pairs_q   <= '0;
      match_p_q <= 1'b0;
      miss_p_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      first_q   <= '0;
      second_q  <= '0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      face_q    <= face_d;
      match_q   <= match_d;
      pairs_q   <= pairs_d;
      match_p_q <= match_p_d;
      miss_p_q  <= miss_p_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      second_q  <= second_d;
    end
  end

  assign cursor      = cursor_q;
  assign face_up     = face_q;
  assign matched     = match_q;
  assign pairs_found = pairs_q;
  assign match_p     = match_p_q;
  assign miss_p      = miss_p_q;
  assign busy        = busy_q;
  assign game_done   = done_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// tb_memory_game_ctrl: directed + random play against
// a card-level reference model of the game.
module tb_memory_game_ctrl;

  localparam int SHOW = 4;
  localparam logic [47:0] LAY = {
    3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd7,
    3'd6, 3'd5, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_sel = 1'b0, restart = 1'b0;
  logic [3:0]  cursor;
  logic [15:0] face_up, matched;
  logic [3:0]  pairs_found;
  logic        match_p, miss_p, busy, game_done;

  memory_game_ctrl #(
    .SHOW_CYCLES(SHOW),
    .CNT_W(3),
    .LAYOUT(LAY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .restart(restart),
    .cursor(cursor), .face_up(face_up),
    .matched(matched), .pairs_found(pairs_found),
    .match_p(match_p), .miss_p(miss_p),
    .busy(busy), .game_done(game_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // reference model: cards, picks in progress, time shown
  int        m_r, m_c, m_pairs, m_age;
  bit [15:0] m_face, m_match;
  int        picks[$];
  bit        m_checking, m_done, m_mp, m_xp;

  function automatic int card_val(input int p);
    logic [47:0] l;
    l = LAY;
    return int'((l >> (3 * p)) & 48'd7);
  endfunction

  function automatic void model_reset();
    m_r = 0; m_c = 0; m_pairs = 0; m_age = 0;
    m_face = '0; m_match = '0;
    picks.delete();
    m_checking = 0; m_done = 0; m_mp = 0; m_xp = 0;
  endfunction

  function automatic void model_step(input bit u, d, l, r,
                                     input bit s, rs);
    int cur, a, b;
    bit mv;
    m_mp = 0; m_xp = 0;
    if (rs) begin
      model_reset();
      return;
    end
    cur = m_r * 4 + m_c;
    mv = u | d | l | r;
    if (!m_done) begin
      if (u) m_r = (m_r + 3) % 4;
      else if (d) m_r = (m_r + 1) % 4;
      else if (l) m_c = (m_c + 3) % 4;
      else if (r) m_c = (m_c + 1) % 4;
    end
    if (m_done) begin
    end else if (m_checking) begin
      a = picks[0]; b = picks[1];
      if (card_val(a) == card_val(b)) begin
        m_match[a] = 1; m_match[b] = 1;
        m_pairs++; m_mp = 1;
        if (m_pairs == 8) begin
          m_done = 1; m_face = '1; m_match = '1;
        end
      end else begin
        m_face[a] = 0; m_face[b] = 0; m_xp = 1;
      end
      picks.delete();
      m_checking = 0;
    end else if (picks.size() == 2) begin
      m_age++;
      if (m_age == SHOW) m_checking = 1;
    end else if (s && !mv && !m_face[cur]) begin
      m_face[cur] = 1;
      picks.push_back(cur);
      m_age = 0;
    end
  endfunction

  task automatic check_all();
    chk_eq("cursor", 32'(cursor), 32'(m_r * 4 + m_c));
    chk_eq("face_up", 32'(face_up), 32'(m_face));
    chk_eq("matched", 32'(matched), 32'(m_match));
    chk_eq("pairs", 32'(pairs_found), 32'(m_pairs));
    chk_eq("match_p", 32'(match_p), 32'(m_mp));
    chk_eq("miss_p", 32'(miss_p), 32'(m_xp));
    chk_eq("busy", 32'(busy), 32'(picks.size() == 2 && !m_done));
    chk_eq("game_done", 32'(game_done), 32'(m_done));
  endtask

  task automatic step(input bit u, d, l, r, s, rs);
    btn_up = u; btn_down = d; btn_left = l;
    btn_right = r; btn_sel = s; restart = rs;
    @(posedge clk);
    model_step(u, d, l, r, s, rs | !rst_n);
    #1;
    check_all();
    btn_up = 0; btn_down = 0; btn_left = 0;
    btn_right = 0; btn_sel = 0; restart = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic goto_pos(input int p);
    for (int i = 0; i < 4 && m_r != p / 4; i++)
      step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4 && m_c != p % 4; i++)
      step(0, 0, 0, 1, 0, 0);
  endtask

  task automatic pick(input int p);
    goto_pos(p);
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic play_pair(input int a, input int b);
    pick(a);
    pick(b);
    idle(SHOW + 1);
  endtask

  initial begin
    int pa, pb;
    bit [5:0] rb;
    model_reset();
    #12;
    check_all();
    chk_eq("reset_face", 32'(face_up), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // cursor moves and wrap
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk_eq("cursor_0111", 32'(cursor), 32'h7);
    step(0, 0, 0, 1, 0, 0);
    chk_eq("cursor_wrap", 32'(cursor), 32'h4);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk_eq("row_wrap", 32'(cursor), 32'hC);
    step(0, 1, 1, 1, 0, 0);
    chk_eq("prio_down", 32'(cursor), 32'h0);
    step(0, 0, 0, 1, 1, 0);
    chk_eq("sel_with_move", 32'(face_up), 32'h0);

    // reselect of the first card is ignored
    pick(0);
    pick(0);
    chk_eq("resel_face", 32'(face_up), 32'h0001);
    chk_eq("resel_busy", 32'(busy), 32'h0);

    // mismatch 0,1
    pick(1);
    chk_eq("miss_show", 32'(face_up), 32'h0003);
    idle(SHOW + 1);
    chk_eq("miss_pulse", 32'(miss_p), 32'h1);
    chk_eq("miss_hide", 32'(face_up), 32'h0);

    // match 0,5
    play_pair(0, 5);
    chk_eq("match_pulse", 32'(match_p), 32'h1);
    chk_eq("match_mask", 32'(matched), 32'h0021);
    chk_eq("match_pairs", 32'(pairs_found), 32'h1);

    // solve the rest
    for (int v = 1; v < 8; v++) begin
      pa = -1; pb = -1;
      for (int p = 0; p < 16; p++)
        if (card_val(p) == v) begin
          if (pa < 0) pa = p; else pb = p;
        end
      play_pair(pa, pb);
    end
    chk_eq("done_flag", 32'(game_done), 32'h1);
    chk_eq("done_pairs", 32'(pairs_found), 32'h8);
    chk_eq("done_face", 32'(face_up), 32'hFFFF);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk_eq("done_frozen", 32'(game_done), 32'h1);
    step(0, 0, 0, 0, 0, 1);
    chk_eq("restart_face", 32'(face_up), 32'h0);
    chk_eq("restart_done", 32'(game_done), 32'h0);
    chk_eq("restart_pairs", 32'(pairs_found), 32'h0);

    // async reset in the middle of SHOW
    pick(0);
    pick(5);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk_eq("arst_face", 32'(face_up), 32'h0);
    chk_eq("arst_busy", 32'(busy), 32'h0);
    idle(2);
    #3 rst_n = 1'b1;
    idle(SHOW + 3);
    chk_eq("arst_no_pulse", 32'(match_p | miss_p), 32'h0);

    // random play
    for (int i = 0; i < 4000; i++) begin
      rb = 6'($urandom);
      step(rb[0] & ($urandom_range(0, 3) == 0),
           rb[1] & ($urandom_range(0, 3) == 0),
           rb[2] & ($urandom_range(0, 3) == 0),
           rb[3] & ($urandom_range(0, 3) == 0),
           rb[4],
           $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
